// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx among NREQ byte producers,
// each with a one-byte holding register. Optional tag bytes: UART_TX_ARBITER_TAG_EN.
module uart_tx_arbiter #(
  parameter int NREQ = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [8*NREQ-1:0]       req_data,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  output logic [7:0]              tx_data,
  output logic                    tx_start,
  input  logic                    tx_busy,
  output logic [$clog2(NREQ)-1:0] grant_id
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, START, ACK, DONE} state_t;

  state_t          state, state_nx;
  logic [NREQ-1:0] full;
  logic [7:0]      hold [NREQ];
  logic [IW-1:0]   rr, win, pick, cand, sel, rr_nx;
  logic            found, avail, load, rel;

`ifdef UART_TX_ARBITER_TAG_EN
  logic          tag_pend, last_valid;
  logic [IW-1:0] last_id;
  logic [7:0]    tag_byte;
`endif

  assign req_ready = ~full;
  assign tx_start  = (state == START);

  // First full register at or after rr, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = IW'((int'(rr) + i) % NREQ);
      if (!found && full[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

`ifdef UART_TX_ARBITER_TAG_EN
  // A pending tag locks the winner so its data byte follows immediately.
  assign sel      = tag_pend ? win : pick;
  assign avail    = tag_pend | found;
  assign rel      = (state == START) && !tag_pend;
  assign tag_byte = {4'hF, 1'b0, 3'(sel)};
`else
  assign sel   = pick;
  assign avail = found;
  assign rel   = (state == START);
`endif

  assign rr_nx = (sel == IW'(NREQ - 1)) ? '0 : sel + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    case (state)
      IDLE: begin
        if (avail && !tx_busy) begin
          load     = 1'b1;
          state_nx = START;
        end
      end
      START:   state_nx = ACK;
      ACK:     if (tx_busy)  state_nx = DONE;
      DONE:    if (!tx_busy) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full     <= '0;
      for (int i = 0; i < NREQ; i++) hold[i] <= 8'h00;
      rr       <= '0;
      win      <= '0;
      tx_data  <= 8'h00;
      grant_id <= '0;
`ifdef UART_TX_ARBITER_TAG_EN
      tag_pend   <= 1'b0;
      last_valid <= 1'b0;
      last_id    <= '0;
`endif
    end else begin
      // Accept overrides release so a refill on the release edge is kept.
      for (int i = 0; i < NREQ; i++) begin
        if (rel && win == IW'(i)) full[i] <= 1'b0;
        if (req_valid[i] && !full[i]) begin
          full[i] <= 1'b1;
          hold[i] <= req_data[8*i +: 8];
        end
      end
      if (load) begin
        win      <= sel;
        grant_id <= sel;
`ifdef UART_TX_ARBITER_TAG_EN
        if (!tag_pend && !(last_valid && last_id == sel)) begin
          tx_data  <= tag_byte;
          tag_pend <= 1'b1;
        end else begin
          tx_data    <= hold[sel];
          tag_pend   <= 1'b0;
          rr         <= rr_nx;
          last_id    <= sel;
          last_valid <= 1'b1;
        end
`else
        tx_data <= hold[sel];
        rr      <= rr_nx;
`endif
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed stimulus pushes expected bytes,
// a monitor pops them on every tx_start.
module tb_uart_tx_arbiter;
  localparam int NREQ = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] req_data;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic [1:0]  grant_id;

  int          checks = 0;
  int          errors = 0;
  int          n_exp = 0;
  int          n_start = 0;
  logic [7:0]  exp_q [$];
  int          bcnt = 0;
  logic        busy_force = 1'b0;

`ifdef UART_TX_ARBITER_TAG_EN
  logic m_valid = 1'b0;
  int   m_id = 0;
`endif

  uart_tx_arbiter #(.NREQ(NREQ)) dut (
    .clk(clk), .rst(rst), .req_data(req_data), .req_valid(req_valid),
    .req_ready(req_ready), .tx_data(tx_data), .tx_start(tx_start),
    .tx_busy(tx_busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  // uart_tx model: busy from the edge after tx_start for 20 cycles
  always @(posedge clk) begin
    if (tx_start) bcnt <= 20;
    else if (bcnt != 0) bcnt <= bcnt - 1;
  end
  assign tx_busy = busy_force | (bcnt != 0);

  always @(negedge clk) begin
    if (!rst && tx_start) begin
      logic [7:0] e;
      n_start++;
      checks++;
      if (tx_busy) begin
        errors++;
        $display("FAIL start_while_busy: tx_start=1 with tx_busy=%0b, required tx_busy=0", tx_busy);
      end
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL spurious_start: tx_data=%02h with no byte expected", tx_data);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (tx_data !== e) begin
          errors++;
          $display("FAIL tx_data: got %02h expected %02h", tx_data, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
`ifdef UART_TX_ARBITER_TAG_EN
    m_valid = 1'b0;
    m_id    = 0;
`endif
  endtask

  task automatic exp_byte(input int id, input logic [7:0] b);
`ifdef UART_TX_ARBITER_TAG_EN
    if (!m_valid || m_id != id) begin
      exp_q.push_back({4'hF, 1'b0, 3'(id)});
      n_exp++;
    end
    m_valid = 1'b1;
    m_id    = id;
`endif
    exp_q.push_back(b);
    n_exp++;
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic send(input int id, input logic [7:0] b);
    int t = 0;
    while (!req_ready[id] && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready[id]) begin
      errors++;
      $display("FAIL send_ready_timeout: req_ready[%0d]=0 after %0d cycles, required 1", id, t);
    end
    req_data[8*id +: 8] = b;
    req_valid[id] = 1'b1;
    @(negedge clk);
    req_valid[id] = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    int quiet = 0;
    while (quiet < 3 && t < 3000) begin
      @(negedge clk);
      t++;
      if (exp_q.size() == 0 && !tx_busy && !tx_start) quiet++;
      else quiet = 0;
    end
    checks++;
    if (quiet < 3) begin
      errors++;
      $display("FAIL drain_timeout: %0d bytes still expected, required 0", exp_q.size());
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    model_reset();
    cycles(1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_data = '0;
    cycles(2);
    check("rst_req_ready", req_ready, 4'hF);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_tx_start", tx_start, 1'b0);
    check("rst_grant_id", grant_id, 2'd0);
    rst = 1'b0;
    model_reset();
    cycles(1);

    // single requester with latency checks
    exp_byte(0, 8'h55);
    send(0, 8'h55);
`ifndef UART_TX_ARBITER_TAG_EN
    check("lat_idle_start", tx_start, 1'b0);
    @(negedge clk);
    check("lat_start", tx_start, 1'b1);
    check("single_grant", grant_id, 2'd0);
    @(negedge clk);
    check("ready_after_start", req_ready[0], 1'b1);
`endif
    drain();

    // round robin from rr=0, then partial refill
    do_reset();
    exp_byte(0, 8'h10); exp_byte(1, 8'h11); exp_byte(2, 8'h12); exp_byte(3, 8'h13);
    req_data = 32'h13121110;
    req_valid = 4'hF;
    @(negedge clk);
    req_valid = 4'h0;
    drain();
    exp_byte(0, 8'h20); exp_byte(2, 8'h22);
    req_data = 32'h00220020;
    req_valid = 4'b0101;
    @(negedge clk);
    req_valid = 4'h0;
    drain();
    check("rr_last_grant", grant_id, 2'd2);

    // back-to-back refills from requester 1
    exp_byte(1, 8'hA1); exp_byte(1, 8'hA2); exp_byte(1, 8'hA3);
    send(1, 8'hA1);
    send(1, 8'hA2);
    send(1, 8'hA3);
    drain();

    // reset during DONE: pending byte on requester 3 must vanish
`ifdef UART_TX_ARBITER_TAG_EN
    exp_q.push_back(8'hF2);
`else
    exp_q.push_back(8'h77);
`endif
    n_exp++;
    send(2, 8'h77);
    cycles(4);
    send(3, 8'h88);
    rst = 1'b1;
    #1;
    check("midrst_tx_start", tx_start, 1'b0);
    check("midrst_req_ready", req_ready, 4'hF);
    check("midrst_grant_id", grant_id, 2'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    drain();
    cycles(30);
    check("midrst_ready_after", req_ready, 4'hF);

    // start blocked by external busy
    busy_force = 1'b1;
    exp_byte(3, 8'h33);
    send(3, 8'h33);
    for (int i = 0; i < 10; i++) begin
      check("blocked_no_start", tx_start, 1'b0);
      @(negedge clk);
    end
    busy_force = 1'b0;
    @(negedge clk);
    check("unblocked_start", tx_start, 1'b1);
    drain();

`ifdef UART_TX_ARBITER_TAG_EN
    // tag sequence: F2,01,02,F0,03
    do_reset();
    exp_byte(2, 8'h01); exp_byte(2, 8'h02);
    send(2, 8'h01);
    send(2, 8'h02);
    drain();
    exp_byte(0, 8'h03);
    send(0, 8'h03);
    drain();
`endif

    check("start_count", n_start, n_exp);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
